// File: rtl/approx_mac_accumulator.sv
// Accumulates signed products into per-vector dot products and hands each result off over a
// valid/ready interface. The result stays registered until the consumer takes it.
module approx_mac_accumulator #(
  parameter int unsigned PROD_W   = 32,
  parameter int unsigned ACC_W    = 40,
  parameter int unsigned CNT_W    = 16,
  parameter bit          SATURATE = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_p,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic [CNT_W-1:0]  out_cnt,
  output logic              out_ovf
);

  localparam int unsigned ExtW = ACC_W + 1 - PROD_W;

  typedef enum logic {StAcc, StHold} state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [ACC_W-1:0]   out_acc_q, out_acc_d;
  logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
  logic               out_ovf_q, out_ovf_d;

  logic               beat;
  logic [ACC_W:0]     sum_wide;
  logic               ovf_beat;
  logic [ACC_W-1:0]   sum;
  logic [CNT_W-1:0]   cnt_inc;

  assign out_valid = (state_q == StHold);
  assign in_ready  = ~out_valid | out_ready;
  assign beat      = in_valid & in_ready;

  // One guard bit beyond ACC_W exposes signed overflow as a mismatch of the top two bits.
  assign sum_wide = {acc_q[ACC_W-1], acc_q} + {{ExtW{in_p[PROD_W-1]}}, in_p};
  assign ovf_beat = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
  assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    sum = sum_wide[ACC_W-1:0];
    if (SATURATE && ovf_beat) begin
      sum = sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    out_acc_d = out_acc_q;
    out_cnt_d = out_cnt_q;
    out_ovf_d = out_ovf_q;

    if (state_q == StHold && out_ready) begin
      state_d = StAcc;
    end

    if (beat) begin
      if (in_last) begin
        out_acc_d = sum;
        out_cnt_d = cnt_inc;
        out_ovf_d = ovf_q | ovf_beat;
        acc_d     = '0;
        cnt_d     = '0;
        ovf_d     = 1'b0;
        state_d   = StHold;
      end else begin
        acc_d = sum;
        cnt_d = cnt_inc;
        ovf_d = ovf_q | ovf_beat;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StAcc;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      out_acc_q <= '0;
      out_cnt_q <= '0;
      out_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      out_acc_q <= out_acc_d;
      out_cnt_q <= out_cnt_d;
      out_ovf_q <= out_ovf_d;
    end
  end

  assign out_acc = out_acc_q;
  assign out_cnt = out_cnt_q;
  assign out_ovf = out_ovf_q;

endmodule
